// File: rtl/timer_pkg.sv
// Shared types and constants for the 1 Hz BCD down-count timer controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENT_T = 3'd1,
    ENT_O = 3'd2,
    READY = 3'd3,
    RUN   = 3'd4,
    PAUSE = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [7:0] BCD_ZERO      = 8'h00;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Saturate a keyed-in digit so the preset can never hold a non-BCD nibble.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status link between the timer controller and the BCD down-counter.
// Latency: none (wiring only).
// Backpressure: none; the counter must act on cnt_load/cnt_en in the cycle they are high.
interface timer_ctrl_if;
  logic       cnt_load;
  logic [7:0] cnt_preset;
  logic       cnt_en;
  logic [7:0] cnt_q;

  modport master (output cnt_load, output cnt_preset, output cnt_en, input  cnt_q);
  modport slave  (input  cnt_load, input  cnt_preset, input  cnt_en, output cnt_q);
endinterface

// File: rtl/timer_ctrl_btn_edge.sv
// Rising-edge detector for a pre-synchronised push-button level.
// Latency: pulse is high for the one cycle following the clock edge that first sees btn=1.
// Backpressure: none; a button held high produces a single pulse.
module btn_edge (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);

  logic prev;

  // Remember last level and register the 0->1 transition.
  always_ff @(posedge clk) begin
    if (clr) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= btn;
      pulse <= btn & ~prev;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/preset sequencer for the BCD down-counter: preset entry, run gating, alarm and blink.
// Latency: button edge to state change is 2 clk; cnt_en is combinational from tick in RUN.
// Backpressure: none; buttons are edge-detected and the counter obeys cnt_load/cnt_en directly.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int         ALARM_SECS = 5,
  parameter logic [7:0] BCD_MAX    = 8'h99
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         tick,
  input  logic         load,
  input  logic         start,
  input  logic [3:0]   in,
  timer_ctrl_if.master cnt,
  output logic         blank,
  output logic         alarm,
  output logic [2:0]   state_o
);

  // Per-nibble ceiling: the tighter of the BCD digit limit and the configured maximum.
  localparam logic [3:0] TENS_MAX   = (BCD_MAX[7:4] > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : BCD_MAX[7:4];
  localparam logic [3:0] ONES_MAX   = (BCD_MAX[3:0] > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : BCD_MAX[3:0];
  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

  state_t     state, state_n;
  logic [7:0] preset, preset_n;
  logic       cnt_load_r, cnt_load_n;
  logic       blank_n;
  logic [3:0] acnt, acnt_n;
  logic       load_e, start_e;
  logic       cnt_zero;

  btn_edge u_load_edge  (.clk(clk), .clr(clr), .btn(load),  .pulse(load_e));
  btn_edge u_start_edge (.clk(clk), .clr(clr), .btn(start), .pulse(start_e));

  assign cnt_zero       = (cnt.cnt_q == BCD_ZERO);
  assign cnt.cnt_en     = (state == RUN) && tick && !cnt_zero;
  assign cnt.cnt_load   = cnt_load_r;
  assign cnt.cnt_preset = preset;
  assign alarm          = (state == DONE);
  assign state_o        = state;

  // State, preset, load strobe, blink and alarm tick counter registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      preset     <= BCD_ZERO;
      cnt_load_r <= 1'b0;
      blank      <= 1'b0;
      acnt       <= 4'd0;
    end else begin
      state      <= state_n;
      preset     <= preset_n;
      cnt_load_r <= cnt_load_n;
      blank      <= blank_n;
      acnt       <= acnt_n;
    end
  end

  // Next-state logic; load beats start everywhere except RUN and DONE where start wins.
  always_comb begin
    state_n    = state;
    preset_n   = preset;
    cnt_load_n = 1'b0;
    blank_n    = blank;
    acnt_n     = acnt;
    case (state)
      IDLE: begin
        if (load_e) state_n = ENT_T;
      end
      ENT_T: begin
        if (load_e) begin
          preset_n[7:4] = clamp_digit(in, TENS_MAX);
          state_n       = ENT_O;
        end
      end
      ENT_O: begin
        if (load_e) begin
          preset_n[3:0] = clamp_digit(in, ONES_MAX);
          cnt_load_n    = 1'b1;
          state_n       = READY;
        end
      end
      READY: begin
        if (load_e)       state_n = ENT_T;
        else if (start_e) state_n = RUN;
      end
      RUN: begin
        if (start_e) begin
          state_n = PAUSE;
        end else if (cnt_zero) begin
          state_n = DONE;
          acnt_n  = 4'd0;
          blank_n = 1'b0;
        end
      end
      PAUSE: begin
        if (load_e)       state_n = ENT_T;
        else if (start_e) state_n = RUN;
      end
      DONE: begin
        if (start_e) begin
          state_n = IDLE;
          acnt_n  = 4'd0;
          blank_n = 1'b0;
        end else if (tick) begin
          if (acnt == ALARM_LAST) begin
            state_n = IDLE;
            acnt_n  = 4'd0;
            blank_n = 1'b0;
          end else begin
            acnt_n  = acnt + 4'd1;
            blank_n = ~blank;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
